uart_tx_serializer: RTL and testbench
=====================================

Name:
uart_tx_serializer

Overview:
- Downstream consumer of the core's 9-bit UART output bus: bit 8 = write strobe, bits 7:0 = byte.
- Buffers bytes written by the core in a small FIFO so back-to-back stores are not lost.
- Serializes each byte onto a single 8N1 TX line.
- Replaces the behavioural print model for synthesis and for bit-accurate simulation.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit (≥2; small default for simulation).
- FIFO_DEPTH, 16, byte entries; power of two, ≥2.
- CNT_W, 5, width of count output; must hold FIFO_DEPTH (log2(FIFO_DEPTH)+1).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- uart_in  input  9  [8] = write strobe (one cycle per byte), [7:0] = byte; driven from core uart_out.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky; a byte was dropped.
- count  output  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, full=0, overflow=0, count=0, FSM=IDLE, FIFO pointers=0, bit timer=0. This applies mid-frame too: the line returns high immediately and the frame is abandoned; no partial stop bit.
- Push: on a rising edge with uart_in[8]=1, uart_in[7:0] is written at the write pointer.
  - A strobe on N consecutive cycles is N separate bytes.
  - Push when full and no pop in the same cycle: byte dropped, overflow←1 until reset.
  - Push and pop in the same cycle while full: push accepted, count unchanged.
  - Push and pop in the same cycle while empty: not possible; pop requires count>0 before the edge.
- Pointers wrap modulo FIFO_DEPTH. full=(count==FIFO_DEPTH). count is registered.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the option).
  - IDLE: if count>0, pop the head byte into the shift register, tx←0, timer←CLKS_PER_BIT-1 → START.
  - START: when timer==0 → DATA, tx←shift[0], bit index←0, timer reloaded.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 expires → STOP, tx←1.
  - STOP: held CLKS_PER_BIT cycles. On expiry, if count>0, pop immediately and go to START (tx←0, no idle gap); else go to IDLE.
- Timer decrements every cycle in non-IDLE states and reloads on every bit transition.
- Latency: a byte pushed at edge E0 into an empty FIFO with FSM idle drives the start bit from edge E1. A frame occupies 10×CLKS_PER_BIT cycles.
- tx is a registered output; no combinational path from uart_in to tx.
- busy=(state!=IDLE)||(count>0), registered-equivalent.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11×CLKS_PER_BIT cycles.
- Undefined: no PARITY state, 8N1 only, 10-bit frames.

Decomposition:
- Shared include uart_defs.vh holds:
  - FSM state encodings (UART_IDLE/START/DATA/PARITY/STOP, 3-bit).
  - UART_STROBE_BIT=8.
  - Default CLKS_PER_BIT.
- One sub-module, uart_byte_fifo:
  - Parameterised synchronous FIFO with push, pop, dout, count, full, empty.
  - Owns the drop/overflow rule.
- The serializer FSM stays in uart_tx_serializer.

Test Plan:
- Reset, then idle 20 cycles → tx=1, busy=0, count=0 throughout.
- Single strobe of 0x41, CLKS_PER_BIT=4 → tx from the next edge: 0 ×4, then 1,0,0,0,0,0,1,0 ×4 each, then 1 ×4. busy drops exactly 40 cycles after tx falls.
- Strobe 0x55 then 0xAA on consecutive cycles → two frames back to back with no idle gap; second start bit immediately follows the first stop bit; count peaks at 1.
- 18 strobes on consecutive cycles (bytes 0x00..0x11) while idle → first byte popped at edge 1, FIFO reaches full; exactly one byte (0x11) dropped, overflow=1. The 17 transmitted bytes are 0x00..0x10 in order.
- Assert reset_n low during DATA bit 3 of 0xFF → tx=1 immediately (before the next edge), count=0, overflow=0. After release, no residual frame.
- With UART_TX_PARITY_EN defined: send 0x07 → parity bit 1; send 0x03 → parity bit 0; frame = 44 cycles.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_pkg
//   Shared definitions for the UART transmit path: FSM state encodings, the
//   position of the write strobe inside the core's 9-bit UART bus, the default
//   bit period and a parity helper.
//   Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state use).
// -----------------------------------------------------------------------------
package uart_tx_serializer_pkg;

    // 3-bit state encodings; PARITY is only entered when UART_TX_PARITY_EN is set.
    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_t;

    // Bit 8 of the core's uart_out bus is the one-cycle write strobe.
    localparam int UART_STROBE_BIT = 8;

    // Small default so simulations of the whole core stay short.
    localparam int UART_DEFAULT_CLKS_PER_BIT = 4;

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
//   Synchronous byte FIFO between the core's write strobe and the serializer.
//   Owns the drop rule: a push into a full FIFO with no pop in the same cycle
//   is discarded and sets the sticky overflow flag.
//   Ports:
//     clock, reset_n   rising-edge clock, asynchronous active-low reset
//     push, din        write request and byte
//     pop              read request (ignored when empty)
//     dout             head byte (valid while !empty)
//     count            registered occupancy, 0..DEPTH
//     full, empty      occupancy flags derived from count
//     overflow         sticky drop indication, cleared only by reset
//   No optional features (UART_TX_PARITY_EN does not affect this block).
// -----------------------------------------------------------------------------
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A simultaneous pop frees the slot the push needs, so a full FIFO still
    // accepts the byte in that case.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   Takes bytes from the core's 9-bit UART output bus, buffers them in
//   uart_byte_fifo and shifts each one out on an 8N1 serial line (LSB first).
//   Optional feature macro: UART_TX_PARITY_EN -- when defined, an even parity
//   bit is inserted between the data bits and the stop bit (8E1).
//   Ports:
//     clock      system clock, rising edge
//     reset_n    asynchronous active-low reset
//     uart_in    [8] write strobe, [7:0] byte
//     tx         registered serial output, idle high
//     busy       frame in flight or bytes waiting
//     full       FIFO holds FIFO_DEPTH bytes
//     overflow   sticky: a byte was dropped
//     count      FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [8:0]       uart_in,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    localparam int TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(CLKS_PER_BIT - 1);

    uart_state_t        state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [7:0]         fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic               parity_bit;
`endif

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (uart_in[UART_STROBE_BIT]),
        .din      (uart_in[7:0]),
        .pop      (fifo_pop),
        .dout     (fifo_dout),
        .count    (count),
        .full     (full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    // Load a new byte from idle, or straight out of an expiring stop bit so
    // queued frames go out with no idle gap between them.
    assign fifo_pop = !fifo_empty &&
                      ((state == UART_IDLE) ||
                       ((state == UART_STOP) && (timer == '0)));

    assign busy = (state != UART_IDLE) || !fifo_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= UART_IDLE;
            tx      <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            unique case (state)
                UART_IDLE: begin
                    if (fifo_pop) begin
                        shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= even_parity(fifo_dout);
`endif
                        tx    <= 1'b0;
                        timer <= RELOAD;
                        state <= UART_START;
                    end
                end

                UART_START: begin
                    if (timer == '0) begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        timer   <= RELOAD;
                        state   <= UART_DATA;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

                UART_DATA: begin
                    if (timer == '0) begin
                        timer <= RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= UART_PARITY;
`else
                            tx    <= 1'b1;
                            state <= UART_STOP;
`endif
                        end else begin
                            // Bit 0 of shift is always the bit on the line.
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                UART_PARITY: begin
                    if (timer == '0) begin
                        tx    <= 1'b1;
                        timer <= RELOAD;
                        state <= UART_STOP;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
`endif

                UART_STOP: begin
                    if (timer == '0) begin
                        if (fifo_pop) begin
                            shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= even_parity(fifo_dout);
`endif
                            tx    <= 1'b0;
                            timer <= RELOAD;
                            state <= UART_START;
                        end else begin
                            state <= UART_IDLE;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    timer <= '0;
                    state <= UART_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Directed bench for uart_tx_serializer (CLKS_PER_BIT=4, FIFO_DEPTH=16).
//   Honours UART_TX_PARITY_EN: frames are 11 bits with the parity bit when
//   the macro is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [8:0]    uart_in;
    logic          tx;
    logic          busy;
    logic          full;
    logic          overflow;
    logic [CW-1:0] count;

    int n_cmp  = 0;
    int n_fail = 0;
    int peak   = 0;

    always #5 clock = ~clock;

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .uart_in  (uart_in),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .count    (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Expected line level for serial bit position idx of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NBITS == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Check every cycle of a frame from cycle 'skip' (0 = first start-bit cycle).
    task automatic check_frame(input logic [7:0] b, input int skip, input string tag);
        for (int c = skip; c < FRAME; c++) begin
            chk($sformatf("%s_tx_c%0d", tag, c), {31'd0, tx}, {31'd0, exp_bit(b, c / CPB)});
            chk($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, 32'd1);
            if (int'(count) > peak) peak = int'(count);
            tick();
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_tx_%0d", tag, i), {31'd0, tx}, 32'd1);
            chk($sformatf("%s_busy_%0d", tag, i), {31'd0, busy}, 32'd0);
            chk($sformatf("%s_count_%0d", tag, i), {27'd0, count}, 32'd0);
            tick();
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        uart_in = {1'b1, b};
        tick();
        uart_in = 9'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        uart_in = 9'd0;
        tick();
        tick();
        chk("rst_tx",   {31'd0, tx},       32'd1);
        chk("rst_busy", {31'd0, busy},     32'd0);
        chk("rst_full", {31'd0, full},     32'd0);
        chk("rst_ovf",  {31'd0, overflow}, 32'd0);
        chk("rst_cnt",  {27'd0, count},    32'd0);
        reset_n = 1'b1;
        idle_check(20, "idle");

        // Single byte 0x41: start bit from the edge after the push.
        push_byte(8'h41);
        chk("a41_cnt_e0",  {27'd0, count}, 32'd1);
        chk("a41_tx_e0",   {31'd0, tx},    32'd1);
        chk("a41_busy_e0", {31'd0, busy},  32'd1);
        tick();
        check_frame(8'h41, 0, "a41");
        chk("a41_busy_end", {31'd0, busy},  32'd0);
        chk("a41_tx_end",   {31'd0, tx},    32'd1);
        chk("a41_cnt_end",  {27'd0, count}, 32'd0);

        // Two consecutive strobes: back-to-back frames, occupancy peaks at 1.
        uart_in = {1'b1, 8'h55};
        tick();
        uart_in = {1'b1, 8'hAA};
        chk("b2b_cnt_e0", {27'd0, count}, 32'd1);
        tick();
        uart_in = 9'd0;
        chk("b2b_cnt_e1", {27'd0, count}, 32'd1);
        peak = int'(count);
        check_frame(8'h55, 0, "b55");
        check_frame(8'hAA, 0, "bAA");
        chk("b2b_peak", peak, 32'd1);
        chk("b2b_busy_end", {31'd0, busy}, 32'd0);

        // 18 strobes: one pops at edge 1, 16 fill the FIFO, 0x11 is dropped.
        for (int i = 0; i < 18; i++) begin
            uart_in = {1'b1, 8'(i)};
            tick();
            if (i == 16) begin
                chk("ovf_full_e16", {31'd0, full},     32'd1);
                chk("ovf_ovf_e16",  {31'd0, overflow}, 32'd0);
            end
        end
        uart_in = 9'd0;
        chk("ovf_ovf",  {31'd0, overflow}, 32'd1);
        chk("ovf_full", {31'd0, full},     32'd1);
        chk("ovf_cnt",  {27'd0, count},    32'd16);
        // Now 16 cycles into the frame carrying 0x00.
        check_frame(8'h00, 16, "ovf00");
        for (int i = 1; i <= 16; i++) begin
            check_frame(8'(i), 0, $sformatf("ovf%02h", i));
        end
        chk("ovf_busy_end", {31'd0, busy},     32'd0);
        chk("ovf_cnt_end",  {27'd0, count},    32'd0);
        chk("ovf_sticky",   {31'd0, overflow}, 32'd1);
        chk("ovf_full_end", {31'd0, full},     32'd0);

        // Reset during DATA bit 3 of 0xFF with another byte queued.
        push_byte(8'hFF);
        uart_in = {1'b1, 8'h00};
        tick();
        uart_in = 9'd0;
        for (int i = 0; i < 17; i++) tick();
        chk("rst_mid_tx_pre",  {31'd0, tx},       32'd1);
        chk("rst_mid_cnt_pre", {27'd0, count},    32'd1);
        chk("rst_mid_ovf_pre", {31'd0, overflow}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_tx",   {31'd0, tx},       32'd1);
        chk("rst_mid_cnt",  {27'd0, count},    32'd0);
        chk("rst_mid_ovf",  {31'd0, overflow}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy},     32'd0);
        #1 reset_n = 1'b1;
        tick();
        idle_check(20, "post_rst1");

        // Reset while the start bit is low: line must return high at once.
        push_byte(8'h00);
        tick();
        chk("rst_sb_tx0", {31'd0, tx}, 32'd0);
        tick();
        chk("rst_sb_tx1", {31'd0, tx}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_sb_tx_async", {31'd0, tx}, 32'd1);
        #1 reset_n = 1'b1;
        tick();
        idle_check(20, "post_rst2");

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones -> parity 1; 0x03 has two -> parity 0.
        push_byte(8'h07);
        tick();
        check_frame(8'h07, 0, "par07");
        chk("par07_busy_end", {31'd0, busy}, 32'd0);
        push_byte(8'h03);
        tick();
        check_frame(8'h03, 0, "par03");
        chk("par03_busy_end", {31'd0, busy}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
